// File: rtl/seg_hc595_display_pkg.sv
// Shared constants for the six-digit HC595 seven-segment driver:
// segment decode, serial frame layout and digit-enable pattern.
package seg_hc595_display_pkg;

    localparam int         FRAME_BITS = 14;
    localparam int         SEL_W      = 6;
    localparam int         SEG_W      = 8;
    localparam logic [5:0] SEL_ALL_ON = 6'b111111;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;

    // Active-low common-anode patterns, entry 0 in the low byte; dp (bit7) always off.
    localparam logic [15:0][7:0] SEG_LUT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // Shift order is bit 0 first: sel[0..5], then seg[7] down to seg[0].
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [SEL_W-1:0] sel,
                                                          input logic [SEG_W-1:0] seg);
        logic [FRAME_BITS-1:0] w;
        w = '0;
        w[SEL_W-1:0] = sel;
        for (int i = 0; i < SEG_W; i++) begin
            w[FRAME_BITS-1-i] = seg[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/seg_hc595_display_hc595_ctrl.sv
// Serialises the {seg, sel} word into two cascaded 74HC595s, one bit per
// four clocks, with a single latch pulse at the end of each frame.
module hc595_ctrl
    import seg_hc595_display_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   sel,
    input  logic [7:0]   seg,
    output logic         stcp,
    output logic         shcp,
    output logic         ds,
    output logic         oe
);

    localparam int            BW       = $clog2(FRAME_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

    logic [1:0]            cnt4_q,   cnt4_d;
    logic [BW-1:0]         bitcnt_q, bitcnt_d;
    logic [FRAME_BITS-1:0] data_q,   data_d;
    logic                  ds_q,     ds_d;
    logic                  shcp_q,   shcp_d;
    logic                  stcp_q,   stcp_d;

    always_comb begin
        cnt4_d   = cnt4_q + 2'd1;
        bitcnt_d = bitcnt_q;
        data_d   = data_q;
        ds_d     = ds_q;
        shcp_d   = shcp_q;
        stcp_d   = 1'b0;

        if (cnt4_q == 2'd3) begin
            bitcnt_d = (bitcnt_q == LAST_BIT) ? '0 : bitcnt_q + BW'(1);
        end

        // Word is frozen for the whole frame so a mid-frame seg change cannot tear it.
        if (bitcnt_q == '0 && cnt4_q == 2'd0) begin
            data_d = build_frame(sel, seg);
        end

        // Bit 0 is driven from the word captured on this same edge.
        if (cnt4_q == 2'd0) begin
            ds_d = data_d[bitcnt_q];
        end

        if (cnt4_q == 2'd2) begin
            shcp_d = 1'b1;
        end else if (cnt4_q == 2'd0) begin
            shcp_d = 1'b0;
        end

        stcp_d = (bitcnt_q == LAST_BIT) && (cnt4_q == 2'd3);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt4_q   <= '0;
            bitcnt_q <= '0;
            data_q   <= '0;
            ds_q     <= 1'b0;
            shcp_q   <= 1'b0;
            stcp_q   <= 1'b0;
        end else begin
            cnt4_q   <= cnt4_d;
            bitcnt_q <= bitcnt_d;
            data_q   <= data_d;
            ds_q     <= ds_d;
            shcp_q   <= shcp_d;
            stcp_q   <= stcp_d;
        end
    end

    assign stcp = stcp_q;
    assign shcp = shcp_q;
    assign ds   = ds_q;
    assign oe   = ~rst;

endmodule

// File: rtl/seg_hc595_display.sv
// Board-level hex counter: a 50 ms timebase steps 0..F, shown on all six
// digits through a cascaded HC595 pair.
module seg_hc595_display
    import seg_hc595_display_pkg::*;
#(
    parameter int TIME_50MS = 2_499_999
) (
    input  logic       clk,
    input  logic       rst,
    output logic [5:0] sel,
    output logic [7:0] seg,
    output logic       stcp,
    output logic       shcp,
    output logic       ds,
    output logic       oe
);

    localparam int            CW      = $clog2(TIME_50MS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIME_50MS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    num_q, num_d;
    logic [5:0]    sel_q, sel_d;
    logic [7:0]    seg_q, seg_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        num_d = num_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            num_d = num_q + 4'd1;
        end
        sel_d = SEL_ALL_ON;
        seg_d = SEG_LUT[num_q];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            num_q <= '0;
            sel_q <= '0;
            seg_q <= SEG_BLANK;
        end else begin
            cnt_q <= cnt_d;
            num_q <= num_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

    hc595_ctrl u_hc595_ctrl (
        .clk  (clk),
        .rst  (rst),
        .sel  (sel_q),
        .seg  (seg_q),
        .stcp (stcp),
        .shcp (shcp),
        .ds   (ds),
        .oe   (oe)
    );

endmodule

// File: tb/tb_seg_hc595_display.sv
// Bench for seg_hc595_display: outputs are predicted from the number of clock
// edges since reset release, using the display and frame rules directly.
module tb_seg_hc595_display;

    localparam int TIME_50MS = 25;
    localparam int PER       = TIME_50MS + 1;
    localparam int FRAME     = 56;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] sel;
    logic [7:0] seg;
    logic       stcp, shcp, ds, oe;

    always #10 clk = ~clk;

    seg_hc595_display #(.TIME_50MS(TIME_50MS)) dut (
        .clk(clk), .rst(rst), .sel(sel), .seg(seg),
        .stcp(stcp), .shcp(shcp), .ds(ds), .oe(oe)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int k      = 0;   // clock edges since reset release
    bit in_rst = 1'b1;

    logic [7:0] lut [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    typedef struct {
        int         k;
        logic [5:0] sel;
        logic [7:0] seg;
        logic       stcp;
        logic       shcp;
        logic       ds;
    } vec_t;

    function automatic logic [7:0] m_seg(int kk);
        if (kk == 0) return 8'hFF;
        return lut[((kk - 1) / PER) % 16];
    endfunction

    function automatic logic [5:0] m_sel(int kk);
        return (kk == 0) ? 6'h00 : 6'h3F;
    endfunction

    function automatic logic m_stcp(int kk);
        return (kk > 0) && (kk % FRAME == 0);
    endfunction

    function automatic logic m_shcp(int kk);
        return (kk > 0) && ((kk % 4 == 3) || (kk % 4 == 0));
    endfunction

    // ds holds the bit loaded at the start of the latest slot; the frame word
    // is whatever sel/seg showed at the frame's first clock.
    function automatic logic m_ds(int kk);
        int m, b, s;
        logic [5:0] sl;
        logic [7:0] sg;
        if (kk == 0) return 1'b0;
        m  = ((kk - 1) / 4) * 4;
        b  = (m / 4) % 14;
        s  = m - (m % FRAME);
        sl = m_sel(s);
        sg = m_seg(s);
        return (b < 6) ? sl[b] : sg[13 - b];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
        end
    endtask

    task automatic check_all();
        chk("sel",  32'(sel),  32'(m_sel(k)));
        chk("seg",  32'(seg),  32'(m_seg(k)));
        chk("stcp", 32'(stcp), 32'(m_stcp(k)));
        chk("shcp", 32'(shcp), 32'(m_shcp(k)));
        chk("ds",   32'(ds),   32'(m_ds(k)));
        chk("oe",   32'(oe),   32'(in_rst));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            if (!in_rst) k++;
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic run_to(input int target);
        while (k < target) step(1);
    endtask

    task automatic do_release();
        @(negedge clk);
        rst = 1'b1; in_rst = 1'b0; k = 0;
        #1 check_all();
    endtask

    task automatic async_reset(input int dly);
        @(posedge clk);
        if (!in_rst) k++;
        #dly;
        rst = 1'b0; in_rst = 1'b1; k = 0;
        #1 check_all();
    endtask

    vec_t       vecs [10];
    logic [13:0] exp_stream;
    logic       got_ds [14];
    logic       prev_shcp;
    int         rises, gap, t0;

    initial begin
        vecs[0] = '{1,   6'h3F, 8'hC0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{26,  6'h3F, 8'hC0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{27,  6'h3F, 8'hF9, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{53,  6'h3F, 8'hA4, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{56,  6'h3F, 8'hA4, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{57,  6'h3F, 8'hA4, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{60,  6'h3F, 8'hA4, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{85,  6'h3F, 8'hB0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{416, 6'h3F, 8'h8E, 1'b0, 1'b1, 1'b1};
        vecs[9] = '{417, 6'h3F, 8'hC0, 1'b0, 1'b0, 1'b1};

        // Power-on reset, released at 200 ns
        #100 check_all();
        #100;
        rst = 1'b1; in_rst = 1'b0; k = 0;
        #1 check_all();

        foreach (vecs[i]) begin
            run_to(vecs[i].k);
            chk("vec_sel",  32'(sel),  32'(vecs[i].sel));
            chk("vec_seg",  32'(seg),  32'(vecs[i].seg));
            chk("vec_stcp", 32'(stcp), 32'(vecs[i].stcp));
            chk("vec_shcp", 32'(shcp), 32'(vecs[i].shcp));
            chk("vec_ds",   32'(ds),   32'(vecs[i].ds));
        end

        // Frame starting at edge 840 carries seg=C0, sel=3F
        run_to(840);
        chk("frame_stcp", 32'(stcp), 32'(1));
        exp_stream = 14'b00000011111111;  // bit i = i-th shifted bit
        prev_shcp = shcp; rises = 0; gap = 0; t0 = k;
        for (int c = 0; c < 120; c++) begin
            step(1);
            if (shcp && !prev_shcp) begin
                if (rises < 14) got_ds[rises] = ds;
                rises++;
            end
            prev_shcp = shcp;
            if (stcp) begin
                gap = k - t0;
                break;
            end
        end
        chk("frame_gap",   32'(gap),   32'(56));
        chk("frame_rises", 32'(rises), 32'(14));
        for (int b = 0; b < 14; b++) chk("frame_ds", 32'(got_ds[b]), 32'(exp_stream[b]));
        step(1);
        chk("stcp_width", 32'(stcp), 32'(0));

        // Reset while bit 7 of a frame is being shifted
        run_to((k / FRAME + 1) * FRAME + 28);
        async_reset(3);
        step(2);
        do_release();
        run_to(55);
        chk("no_early_stcp", 32'(stcp), 32'(0));
        step(1);
        chk("restart_stcp", 32'(stcp), 32'(1));

        // Random run lengths and reset phases
        for (int it = 0; it < 8; it++) begin
            step($urandom_range(1, 300));
            async_reset($urandom_range(1, 8));
            step($urandom_range(1, 3));
            do_release();
        end

        // 16 us of free running
        repeat (800) begin
            step(1);
            chk("no_x",   32'($isunknown({sel, seg, stcp, shcp, ds, oe})), 32'(0));
            chk("oe_low", 32'(oe), 32'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
